// File: rtl/rapcore_spi_pkg.sv
// rapcore_spi_pkg: shared constants and state encoding for the RAPcore SPI command front end.
// Revision: 1.0
`default_nettype none

package rapcore_spi_pkg;

  localparam int SPI_WORD_BITS      = 64;
  localparam int SPI_BYTE_BITS      = 8;
  localparam bit SPI_LSB_BYTE_FIRST = 1'b1;
  localparam int SPI_SYNC_STAGES    = 2;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop pin synchronizer with optional registered rise/fall pulses.
// Revision: 1.0
`default_nettype none

module spi_sync_edge #(
  parameter int STAGES    = 2,
  parameter bit RESET_VAL = 1'b0,
  parameter bit EDGE_EN   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic r_prev;
      logic r_rise;
      logic r_fall;

      // Edge pulses are registered so they line up one cycle after the synchronized level changes.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_prev <= RESET_VAL;
          r_rise <= 1'b0;
          r_fall <= 1'b0;
        end else begin
          r_prev <= o_q;
          r_rise <= o_q & ~r_prev;
          r_fall <= ~o_q & r_prev;
        end
      end

      assign o_rise = r_rise;
      assign o_fall = r_fall;
    end else begin : g_no_edge
      assign o_rise = 1'b0;
      assign o_fall = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/spi_word_target.sv
// spi_word_target: oversampled SPI mode-0 target assembling LSB-byte-first command words.
// Readback path enabled by defining SPI_TARGET_TX_EN. Revision: 1.0
`default_nettype none

module spi_word_target
  import rapcore_spi_pkg::*;
#(
  parameter int WORD_BITS   = SPI_WORD_BITS,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic                 CLK,
  input  logic                 resetn,
  input  logic                 SCK,
  input  logic                 CS,
  input  logic                 COPI,
  output logic                 CIPO,
  output logic [WORD_BITS-1:0] rx_word,
  output logic                 rx_valid,
  output logic                 rx_abort,
  input  logic [WORD_BITS-1:0] tx_word,
  input  logic                 tx_load,
  output logic                 tx_ready,
  output logic                 tx_underrun,
  output logic                 busy
);

  localparam int             BYTES     = WORD_BITS / SPI_BYTE_BITS;
  localparam int             BW        = $clog2(BYTES);
  localparam logic [BW-1:0]  LAST_BYTE = BW'(BYTES - 1);

  logic w_sck_q, w_sck_rise, w_sck_fall;
  logic w_cs_q, w_cs_rise, w_cs_fall;
  logic w_copi, w_copi_rise, w_copi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_EN(1'b1)) u_sync_sck (
    .clk(CLK), .rst_n(resetn), .i_d(SCK), .o_q(w_sck_q), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1), .EDGE_EN(1'b1)) u_sync_cs (
    .clk(CLK), .rst_n(resetn), .i_d(CS), .o_q(w_cs_q), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_EN(1'b0)) u_sync_copi (
    .clk(CLK), .rst_n(resetn), .i_d(COPI), .o_q(w_copi), .o_rise(w_copi_rise), .o_fall(w_copi_fall)
  );

  logic w_unused_sync;
  assign w_unused_sync = &{1'b0, w_sck_q, w_cs_q, w_copi_rise, w_copi_fall};

  spi_state_t           r_state;
  logic [2:0]           r_bit_cnt;
  logic [BW-1:0]        r_byte_cnt;
  logic [6:0]           r_byte;
  logic [WORD_BITS-1:0] r_asm;
  logic [WORD_BITS-1:0] r_rx_word;
  logic                 r_rx_valid;
  logic                 r_rx_abort;

  logic [7:0]           w_byte;
  logic [BW-1:0]        w_lane;
  logic [WORD_BITS-1:0] w_asm_next;
  logic                 w_word_done;
  logic                 w_word_start;

  assign w_byte       = {r_byte, w_copi};
  assign w_lane       = SPI_LSB_BYTE_FIRST ? r_byte_cnt : (LAST_BYTE - r_byte_cnt);
  assign w_word_done  = (r_state == ST_ACTIVE) && !w_cs_rise && w_sck_rise &&
                        (r_bit_cnt == 3'd7) && (r_byte_cnt == LAST_BYTE);
  assign w_word_start = ((r_state == ST_IDLE) && w_cs_fall) || w_word_done;

  always_comb begin
    w_asm_next = r_asm;
    w_asm_next[{w_lane, 3'b000} +: 8] = w_byte;
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd0;
      r_byte_cnt <= '0;
      r_byte     <= 7'd0;
      r_asm      <= '0;
      r_rx_word  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_abort <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_abort <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_state    <= ST_ACTIVE;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= '0;
          end
        end
        ST_ACTIVE: begin
          if (w_cs_rise) begin
            r_state    <= ST_IDLE;
            r_rx_abort <= (r_bit_cnt != 3'd0) || (r_byte_cnt != '0);
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= '0;
          end else if (w_sck_rise) begin
            r_byte    <= w_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_asm <= w_asm_next;
              if (r_byte_cnt == LAST_BYTE) begin
                r_rx_word  <= w_asm_next;
                r_rx_valid <= 1'b1;
                r_byte_cnt <= '0;
              end else begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rx_word  = r_rx_word;
  assign rx_valid = r_rx_valid;
  assign rx_abort = r_rx_abort;
  assign busy     = (r_state == ST_ACTIVE);

`ifdef SPI_TARGET_TX_EN
  localparam logic [BW-1:0] FIRST_LANE = SPI_LSB_BYTE_FIRST ? '0 : LAST_BYTE;

  logic [WORD_BITS-1:0] r_hold;
  logic [WORD_BITS-1:0] r_tx_sh;
  logic                 r_hold_full;
  logic                 r_cipo;
  logic                 r_underrun;

  // The bit on the wire is indexed by the receive counters, so a wrap needs no extra bookkeeping.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_hold      <= '0;
      r_tx_sh     <= '0;
      r_hold_full <= 1'b0;
      r_cipo      <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      if (w_word_start) begin
        if (r_hold_full) begin
          r_tx_sh     <= r_hold;
          r_cipo      <= r_hold[{FIRST_LANE, 3'b111}];
          r_hold_full <= 1'b0;
        end else begin
          r_tx_sh    <= '0;
          r_cipo     <= 1'b0;
          r_underrun <= 1'b1;
          if (tx_load) begin
            r_hold      <= tx_word;
            r_hold_full <= 1'b1;
          end
        end
      end else begin
        if (tx_load && !r_hold_full) begin
          r_hold      <= tx_word;
          r_hold_full <= 1'b1;
        end
        if ((r_state == ST_ACTIVE) && w_sck_fall) begin
          r_cipo <= r_tx_sh[{w_lane, ~r_bit_cnt}];
        end
      end
    end
  end

  assign CIPO        = r_cipo;
  assign tx_ready    = ~r_hold_full;
  assign tx_underrun = r_underrun;
`else
  logic w_unused_tx;
  assign w_unused_tx = &{1'b0, tx_word, tx_load, w_word_start, w_sck_fall};

  assign CIPO        = 1'b0;
  assign tx_ready    = 1'b0;
  assign tx_underrun = 1'b0;
`endif

endmodule

`default_nettype wire
